// File: rtl/alu_mdu_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_mdu_decoder: ALU_Control decode plus iterative multiply unit (Hi/Lo). |
// | Define MDU_DIV_EN to add restoring div/divu on the same datapath.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_mdu_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            ALU_Op,
  input  logic [5:0]            Funct,
  input  logic                  Op_Valid,
  input  logic [DATA_WIDTH-1:0] Src_A,
  input  logic [DATA_WIDTH-1:0] Src_B,
  output logic [CTRL_WIDTH-1:0] ALU_Control,
  output logic                  Stall,
  output logic                  Mdu_Done,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [5:0]       FN_MULT   = 6'b011000;
  localparam logic [5:0]       FN_MULTU  = 6'b011001;
  localparam logic [5:0]       FN_DIV    = 6'b011010;
  localparam logic [5:0]       FN_DIVU   = 6'b011011;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [2*W-1:0]     p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [W-1:0]       hi_q, hi_d;
  logic [W-1:0]       lo_q, lo_d;
  logic               done_q, done_d;

  logic [2:0] ctrl;
  always_comb begin
    ctrl = 3'b000;
    case (ALU_Op)
      2'b00:   ctrl = 3'b000;
      2'b01:   ctrl = 3'b001;
      2'b10:   ctrl = 3'b110;
      default: begin
        if (Funct == FN_MULT || Funct == FN_MULTU) ctrl = 3'b010;
`ifdef MDU_DIV_EN
        else if (Funct == FN_DIV || Funct == FN_DIVU) ctrl = 3'b011;
`endif
        else ctrl = 3'b111;
      end
    endcase
  end
  assign ALU_Control = CTRL_WIDTH'(ctrl);

  logic is_mul, is_div, is_signed, start;
  logic [W-1:0] mag_a, mag_b;
  assign is_mul    = (Funct == FN_MULT) | (Funct == FN_MULTU);
`ifdef MDU_DIV_EN
  assign is_div    = (Funct == FN_DIV) | (Funct == FN_DIVU);
`else
  assign is_div    = 1'b0;
`endif
  assign is_signed = ~Funct[0];
  assign start     = (state_q == IDLE) & Op_Valid & (ALU_Op == 2'b11) & (is_mul | is_div);
  assign mag_a     = (is_signed & Src_A[W-1]) ? -Src_A : Src_A;
  assign mag_b     = (is_signed & Src_B[W-1]) ? -Src_B : Src_B;

  // Multiply step: p holds {partial product, remaining multiplier bits}.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next, prod;
  assign mul_sum  = {1'b0, p_q[2*W-1:W]} + {1'b0, (p_q[0] ? a_q : '0)};
  assign mul_next = {mul_sum, p_q[W-1:1]};
  assign prod     = neg_q ? -mul_next : mul_next;

`ifdef MDU_DIV_EN
  // Restoring divide step: p holds {partial remainder, dividend/quotient bits}.
  logic           div_q, div_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [W:0]     rem_sh, diff;
  logic [2*W-1:0] div_next;
  logic [W-1:0]   quo, rem;
  assign rem_sh   = p_q[2*W-1:W-1];
  assign diff     = rem_sh - {1'b0, a_q};
  assign div_next = diff[W] ? {rem_sh[W-1:0], p_q[W-2:0], 1'b0}
                            : {diff[W-1:0],   p_q[W-2:0], 1'b1};
  assign quo      = dz_q ? '1 : (neg_q ? -div_next[W-1:0] : div_next[W-1:0]);
  assign rem      = rneg_q ? -div_next[2*W-1:W] : div_next[2*W-1:W];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d   = is_signed & (Src_A[W-1] ^ Src_B[W-1]);
          a_d     = mag_a;
          p_d     = {{W{1'b0}}, mag_b};
          cnt_d   = '0;
          state_d = RUN;
`ifdef MDU_DIV_EN
          div_d  = is_div;
          rneg_d = is_signed & Src_A[W-1];
          dz_d   = (Src_B == '0);
          if (is_div) begin
            a_d = mag_b;
            p_d = {{W{1'b0}}, mag_a};
          end
`endif
        end
      end
      RUN: begin
        p_d   = mul_next;
        cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIV_EN
        if (div_q) p_d = div_next;
`endif
        if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          done_d       = 1'b1;
          {hi_d, lo_d} = prod;
`ifdef MDU_DIV_EN
          if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MDU_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign Stall    = start | (state_q == RUN);
  assign Mdu_Done = done_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_mdu_decoder: scoreboard bench for decode, multiply (and divide).   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_mdu_decoder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ALU_Op;
  logic [5:0]   Funct;
  logic         Op_Valid;
  logic [W-1:0] Src_A, Src_B;
  logic [2:0]   ALU_Control;
  logic         Stall, Mdu_Done;
  logic [W-1:0] Hi, Lo;

  alu_mdu_decoder #(.DATA_WIDTH(W), .CTRL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .ALU_Op(ALU_Op), .Funct(Funct), .Op_Valid(Op_Valid),
    .Src_A(Src_A), .Src_B(Src_B), .ALU_Control(ALU_Control), .Stall(Stall),
    .Mdu_Done(Mdu_Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every Mdu_Done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (Mdu_Done !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected Mdu_Done", 32'(Mdu_Done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, " Hi"}, Hi, mon_e.hi);
        check({mon_e.name, " Lo"}, Lo, mon_e.lo);
        check({mon_e.name, " done cycle"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic mdu_run(input string nm, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input bit hold);
    int bad;
    @(negedge clk);
    ALU_Op = 2'b11; Funct = fn; Src_A = a; Src_B = b; Op_Valid = 1'b1;
    #1;
    check({nm, " stall at start"}, 32'(Stall), 32'd1);
    sb.push_back('{ehi, elo, cyc + 33, nm});
    last_hi = ehi;
    last_lo = elo;
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (!hold && k == 1) begin
        Op_Valid = 1'b0;
        ALU_Op   = 2'b01;
        #1;
        check({nm, " ctrl tracks in RUN"}, 32'(ALU_Control), 32'd1);
      end
      if (Stall !== (k <= 32)) bad++;
      if (hold && k == 33) Op_Valid = 1'b0;
    end
    check({nm, " stall window"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({nm, " stall after done"}, 32'(Stall), 32'd0);
    check({nm, " result delivered"}, 32'(sb.size()), 32'd0);
  endtask

  logic [2:0] dec_exp [12] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001,
                               3'b110, 3'b110, 3'b110, 3'b111, 3'b010, 3'b111};
  logic [5:0] fn_tab  [3]  = '{6'b100000, 6'b011000, 6'b000000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    reset = 1'b1; ALU_Op = 2'b00; Funct = 6'd0; Op_Valid = 1'b0; Src_A = '0; Src_B = '0;
    repeat (2) @(negedge clk);
    check("reset Hi", Hi, 32'd0);
    check("reset Lo", Lo, 32'd0);
    check("reset Mdu_Done", 32'(Mdu_Done), 32'd0);
    check("reset Stall", 32'(Stall), 32'd0);
    reset = 1'b0;

    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 3; f++) begin
        ALU_Op = 2'(op);
        Funct  = fn_tab[f];
        #1;
        check($sformatf("decode op%0d fn%0d", op, f), 32'(ALU_Control), 32'(dec_exp[op*3+f]));
        check($sformatf("decode op%0d fn%0d no X", op, f), 32'($isunknown(ALU_Control)), 32'd0);
      end
    end
    ALU_Op = 2'b11; Funct = 6'b011001; #1;
    check("decode multu", 32'(ALU_Control), 32'd2);
    Funct = 6'b011010; #1;
`ifdef MDU_DIV_EN
    check("decode div", 32'(ALU_Control), 32'd3);
`else
    check("decode div as slti", 32'(ALU_Control), 32'd7);
`endif

    mdu_run("mult 7x6",       6'b011000, 32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A, 1'b0);
    mdu_run("mult -3x5",      6'b011000, -32'sd3,      32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    mdu_run("mult min x 2 held", 6'b011000, 32'h8000_0000, 32'd2,    32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    mdu_run("mult min x min", 6'b011000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    mdu_run("mult 0 x 12345", 6'b011000, 32'd0,        32'd12345,    32'h0000_0000, 32'h0000_0000, 1'b0);
    mdu_run("multu max x max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    // Reset in the middle of a multiply: no result may ever be delivered.
    @(negedge clk);
    ALU_Op = 2'b11; Funct = 6'b011000; Src_A = 32'd7; Src_B = 32'd6; Op_Valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      Op_Valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("mid-run reset Stall", 32'(Stall), 32'd0);
    check("mid-run reset Hi", Hi, 32'd0);
    check("mid-run reset Lo", Lo, 32'd0);
    check("mid-run reset Mdu_Done", 32'(Mdu_Done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (Stall !== 1'b0 || Hi !== '0 || Lo !== '0) bad++;
    end
    check("after reset idle", 32'(bad), 32'd0);

    mdu_run("mult 7x6 after reset", 6'b011000, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 1'b0);

`ifdef MDU_DIV_EN
    mdu_run("div 100/7",  6'b011010, 32'd100,   32'd7, 32'd2,         32'd14,        1'b0);
    mdu_run("div -100/7", 6'b011010, -32'sd100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
    mdu_run("divu 5/0",   6'b011011, 32'd5,     32'd0, 32'd5,         32'hFFFF_FFFF, 1'b0);
`else
    @(negedge clk);
    ALU_Op = 2'b11; Funct = 6'b011010; Src_A = 32'd100; Src_B = 32'd7; Op_Valid = 1'b1;
    #1;
    check("div disabled no stall", 32'(Stall), 32'd0);
    repeat (3) @(negedge clk);
    Op_Valid = 1'b0;
    check("div disabled Hi held", Hi, last_hi);
    check("div disabled Lo held", Lo, last_lo);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
